// File: rtl/mem_access_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and data load/store (D).
// Owns the MOV/MOC handshake and the RAM bus fields; returns data and done pulses.
module mem_access_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_data,
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [1:0]        d_type,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              err,
  output logic              MOV,
  output logic              RW,
  output logic [1:0]        typeData,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut,
  input  logic              MOC
);

  localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [1:0]  TYPE_WORD = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e state_q, state_d;

  // last_d_q doubles as the owner of the access in flight (1 = D, 0 = IF)
  logic              last_d_q, last_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              if_gnt_q, if_gnt_d;
  logic              d_gnt_q, d_gnt_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              err_q, err_d;
  logic              mov_q, mov_d;
  logic              rw_q, rw_d;
  logic [1:0]        type_q, type_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic any_req_c;
  logic pick_d_c;
  logic timeout_hit_c;

  assign any_req_c     = if_req || d_req;
  // On a tie the requester that did not win last time goes first
  assign pick_d_c      = d_req && (!if_req || !last_d_q);
  assign timeout_hit_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // State register with synchronous active-low clear
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant from IDLE, finish on MOC or timeout, drain MOC in RELEASE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (any_req_c) state_d = S_ACCESS;
      S_ACCESS:  if (MOC || timeout_hit_c) state_d = S_RELEASE;
      S_RELEASE: if (!MOC) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values; pulses default low, everything else holds
  always_comb begin
    last_d_d  = last_d_q;
    cnt_d     = cnt_q;
    if_gnt_d  = 1'b0;
    d_gnt_d   = 1'b0;
    if_done_d = 1'b0;
    d_done_d  = 1'b0;
    err_d     = 1'b0;
    mov_d     = mov_q;
    rw_d      = rw_q;
    type_d    = type_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    if_data_d = if_data_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (any_req_c) begin
          mov_d    = 1'b1;
          cnt_d    = '0;
          last_d_d = pick_d_c;
          if (pick_d_c) begin
            d_gnt_d = 1'b1;
            rw_d    = d_rw;
            type_d  = d_type;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            if_gnt_d = 1'b1;
            rw_d     = 1'b1;
            type_d   = TYPE_WORD;
            addr_d   = if_addr;
            wdata_d  = '0;
          end
        end
      end
      S_ACCESS: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (MOC || timeout_hit_c) begin
          mov_d = 1'b0;
          err_d = !MOC;
          if (last_d_q) begin
            d_done_d = 1'b1;
          end else begin
            if_done_d = 1'b1;
          end
          // MOC beats a coincident timeout; only completed reads capture data
          if (MOC && rw_q) begin
            if (last_d_q) begin
              d_rdata_d = DataOut;
            end else begin
              if_data_d = DataOut;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      last_d_q  <= 1'b1;
      cnt_q     <= '0;
      if_gnt_q  <= 1'b0;
      d_gnt_q   <= 1'b0;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      mov_q     <= 1'b0;
      rw_q      <= 1'b0;
      type_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      if_gnt_q  <= if_gnt_d;
      d_gnt_q   <= d_gnt_d;
      if_done_q <= if_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      mov_q     <= mov_d;
      rw_q      <= rw_d;
      type_q    <= type_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      if_data_q <= if_data_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign if_gnt   = if_gnt_q;
  assign d_gnt    = d_gnt_q;
  assign if_done  = if_done_q;
  assign d_done   = d_done_q;
  assign err      = err_q;
  assign MOV      = mov_q;
  assign RW       = rw_q;
  assign typeData = type_q;
  assign address  = addr_q;
  assign DataIn   = wdata_q;
  assign if_data  = if_data_q;
  assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: directed scenarios plus random traffic against a
// transaction-level model of the arbiter, compared every cycle on the falling edge.
module tb_mem_access_arbiter;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_type = '0;
  logic [7:0]  d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] DataOut = '0;
  logic        MOC = 1'b0;
  logic        if_gnt, if_done, d_gnt, d_done, err, MOV, RW;
  logic [31:0] if_data, d_rdata, DataIn;
  logic [1:0]  typeData;
  logic [7:0]  address;

  mem_access_arbiter #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .CLR(CLR),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_data(if_data),
    .d_req(d_req), .d_rw(d_rw), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .MOV(MOV), .RW(RW), .typeData(typeData), .address(address), .DataIn(DataIn),
    .DataOut(DataOut), .MOC(MOC)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit          is_d;
    bit          rd;
    logic [1:0]  ty;
    logic [7:0]  a;
    logic [31:0] wd;
  } txn_t;

  txn_t        m_cur;
  int          m_phase = 0;   // 0 free, 1 waiting on RAM, 2 waiting for MOC to clear
  int          m_age = 0;
  bit          m_last_d = 1'b1;
  logic        e_if_gnt = 0, e_d_gnt = 0, e_if_done = 0, e_d_done = 0, e_err = 0;
  logic        e_MOV = 0, e_RW = 0;
  logic [1:0]  e_type = 0;
  logic [7:0]  e_addr = 0;
  logic [31:0] e_din = 0, e_if_data = 0, e_d_rdata = 0;

  task automatic model_step();
    bit pick_d;
    e_if_gnt = 0; e_d_gnt = 0; e_if_done = 0; e_d_done = 0; e_err = 0;
    if (!CLR) begin
      e_MOV = 0; e_RW = 0; e_type = 0; e_addr = 0; e_din = 0;
      e_if_data = 0; e_d_rdata = 0;
      m_phase = 0; m_age = 0; m_last_d = 1'b1;
    end else if (m_phase == 0) begin
      if (if_req || d_req) begin
        pick_d     = d_req && (!if_req || !m_last_d);
        m_last_d   = pick_d;
        m_cur.is_d = pick_d;
        m_cur.rd   = pick_d ? d_rw : 1'b1;
        m_cur.ty   = pick_d ? d_type : 2'b10;
        m_cur.a    = pick_d ? d_addr : if_addr;
        m_cur.wd   = pick_d ? d_wdata : 32'h0;
        e_MOV = 1; e_RW = m_cur.rd; e_type = m_cur.ty; e_addr = m_cur.a; e_din = m_cur.wd;
        if (pick_d) e_d_gnt = 1; else e_if_gnt = 1;
        m_age = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_age++;
      if (MOC || m_age == TMO) begin
        e_MOV = 0;
        e_err = !MOC;
        if (m_cur.is_d) e_d_done = 1; else e_if_done = 1;
        if (MOC && m_cur.rd) begin
          if (m_cur.is_d) e_d_rdata = DataOut; else e_if_data = DataOut;
        end
        m_phase = 2;
      end
    end else if (!MOC) begin
      m_phase = 0;
    end
  endtask

  task automatic compare_all();
    chk("if_gnt", 64'(if_gnt), 64'(e_if_gnt));
    chk("d_gnt", 64'(d_gnt), 64'(e_d_gnt));
    chk("if_done", 64'(if_done), 64'(e_if_done));
    chk("d_done", 64'(d_done), 64'(e_d_done));
    chk("err", 64'(err), 64'(e_err));
    chk("MOV", 64'(MOV), 64'(e_MOV));
    chk("RW", 64'(RW), 64'(e_RW));
    chk("typeData", 64'(typeData), 64'(e_type));
    chk("address", 64'(address), 64'(e_addr));
    chk("DataIn", 64'(DataIn), 64'(e_din));
    chk("if_data", 64'(if_data), 64'(e_if_data));
    chk("d_rdata", 64'(d_rdata), 64'(e_d_rdata));
  endtask

  // ---------------- RAM and requester stimulus ----------------
  bit          rand_mode = 0;
  bit          hold_mode = 0;
  int          ram_age = 0;
  int          ram_delay = 1;
  int          ram_hold = 0;
  int          ram_hold_left = 0;
  logic [31:0] ram_data = '0;

  int          mov_cycles = 0;
  bit          last_done_err = 0;
  bit          gnt_log[$];

  task automatic observe();
    if (MOV) mov_cycles++;
    if (if_gnt) gnt_log.push_back(1'b0);
    if (d_gnt) gnt_log.push_back(1'b1);
    if (if_done || d_done) last_done_err = err;
  endtask

  task automatic ram_drive();
    if (MOV) begin
      ram_age++;
      if (!MOC && ram_age > ram_delay) begin
        MOC = 1'b1;
        DataOut = rand_mode ? $urandom : ram_data;
        ram_hold_left = ram_hold;
      end
    end else begin
      if (ram_age != 0 && rand_mode) begin
        ram_delay = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(0, 4));
        ram_hold  = int'($urandom_range(0, 3));
      end
      ram_age = 0;
      if (MOC) begin
        if (ram_hold_left > 0) ram_hold_left--;
        else MOC = 1'b0;
      end
    end
    if (!MOC) DataOut = $urandom;
  endtask

  task automatic req_drive();
    if (!hold_mode && if_gnt) if_req = 1'b0;
    else if (rand_mode && !if_req && $urandom_range(0, 3) == 0) begin
      if_req = 1'b1; if_addr = 8'($urandom);
    end else if (rand_mode && if_req && $urandom_range(0, 40) == 0) if_req = 1'b0;
    if (!hold_mode && d_gnt) d_req = 1'b0;
    else if (rand_mode && !d_req && $urandom_range(0, 3) == 0) begin
      d_req = 1'b1; d_rw = 1'($urandom); d_type = 2'($urandom);
      d_addr = 8'($urandom); d_wdata = $urandom;
    end else if (rand_mode && d_req && $urandom_range(0, 40) == 0) d_req = 1'b0;
  endtask

  task automatic cycle();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare_all();
    observe();
    ram_drive();
    req_drive();
    cyc++;
  endtask

  task automatic wait_done(input string name, input bit want_d, input int bound);
    bit got = 0;
    for (int i = 0; i < bound && !got; i++) begin
      cycle();
      got = want_d ? d_done : if_done;
    end
    chk(name, 64'(got), 64'd1);
  endtask

  initial begin
    int t_done;
    int t_gnt;
    bit got;

    // Reset state
    CLR = 1'b0;
    repeat (3) cycle();
    chk("reset_MOV", 64'(MOV), 64'd0);
    chk("reset_if_data", 64'(if_data), 64'd0);
    chk("reset_d_gnt", 64'(d_gnt), 64'd0);
    CLR = 1'b1;
    cycle();

    // IF word read, MOC two cycles after MOV
    ram_delay = 2; ram_hold = 0; ram_data = 32'h1AFFFFFD;
    mov_cycles = 0;
    if_req = 1'b1; if_addr = 8'h04;
    cycle();
    chk("t1_if_gnt", 64'(if_gnt), 64'd1);
    chk("t1_RW", 64'(RW), 64'd1);
    chk("t1_type", 64'(typeData), 64'd2);
    chk("t1_addr", 64'(address), 64'h04);
    wait_done("t1_done_seen", 1'b0, 20);
    chk("t1_if_data", 64'(if_data), 64'h1AFFFFFD);
    chk("t1_mov_cycles", 64'(mov_cycles), 64'd3);
    repeat (2) cycle();

    // D byte write
    d_req = 1'b1; d_rw = 1'b0; d_type = 2'b00; d_addr = 8'h10; d_wdata = 32'hA5;
    ram_delay = 1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (MOV) begin
        chk("t2_RW", 64'(RW), 64'd0);
        chk("t2_type", 64'(typeData), 64'd0);
        chk("t2_addr", 64'(address), 64'h10);
        chk("t2_DataIn", 64'(DataIn), 64'hA5);
      end
      got = d_done;
    end
    chk("t2_done_seen", 64'(got), 64'd1);
    chk("t2_d_rdata", 64'(d_rdata), 64'd0);
    repeat (2) cycle();

    // Both requests held from reset alternate IF, D, IF, D
    CLR = 1'b0; hold_mode = 1'b1; if_req = 1'b1; d_req = 1'b1;
    d_rw = 1'b1; d_type = 2'b10; d_addr = 8'h44; if_addr = 8'h08;
    ram_delay = 1; ram_hold = 0;
    repeat (2) cycle();
    CLR = 1'b1;
    gnt_log.delete();
    for (int i = 0; i < 40 && gnt_log.size() < 4; i++) cycle();
    chk("t3_gnt_count", 64'(gnt_log.size() >= 4), 64'd1);
    if (gnt_log.size() >= 4) begin
      chk("t3_gnt0", 64'(gnt_log[0]), 64'd0);
      chk("t3_gnt1", 64'(gnt_log[1]), 64'd1);
      chk("t3_gnt2", 64'(gnt_log[2]), 64'd0);
      chk("t3_gnt3", 64'(gnt_log[3]), 64'd1);
    end
    hold_mode = 1'b0; if_req = 1'b0; d_req = 1'b0;
    repeat (10) cycle();

    // MOC never arrives: abort after TIMEOUT cycles with err
    ram_delay = 1000; mov_cycles = 0; last_done_err = 0;
    if_req = 1'b1; if_addr = 8'h0C;
    wait_done("t4_done_seen", 1'b0, 40);
    chk("t4_err_with_done", 64'(last_done_err), 64'd1);
    chk("t4_mov_cycles", 64'(mov_cycles), 64'd15);
    chk("t4_if_data_kept", 64'(if_data), 64'h1AFFFFFD);
    repeat (3) cycle();

    // MOC held 4 cycles after the access: no grant until it clears
    ram_delay = 1; ram_hold = 4; ram_data = 32'h55AA55AA;
    d_req = 1'b1; d_rw = 1'b1; d_type = 2'b10; d_addr = 8'h30;
    wait_done("t5_done_seen", 1'b1, 20);
    t_done = cyc;
    chk("t5_d_rdata", 64'(d_rdata), 64'h55AA55AA);
    if_req = 1'b1; if_addr = 8'h40; ram_hold = 0;
    t_gnt = -1;
    for (int i = 0; i < 20 && t_gnt < 0; i++) begin
      cycle();
      if (if_gnt) t_gnt = cyc;
    end
    chk("t5_gnt_gap", 64'(t_gnt - t_done), 64'd6);
    wait_done("t5_if_done_seen", 1'b0, 20);
    repeat (3) cycle();

    // Reset in the middle of an access
    ram_delay = 1000;
    if_req = 1'b1; if_addr = 8'h50;
    for (int i = 0; i < 10 && !if_gnt; i++) cycle();
    repeat (2) cycle();
    CLR = 1'b0;
    cycle();
    chk("t6_MOV", 64'(MOV), 64'd0);
    chk("t6_done", 64'(if_done), 64'd0);
    chk("t6_if_data", 64'(if_data), 64'd0);
    CLR = 1'b1; ram_delay = 1; ram_data = 32'hCAFE0001;
    if_req = 1'b1; if_addr = 8'h20;
    wait_done("t6_next_done", 1'b0, 20);
    chk("t6_next_data", 64'(if_data), 64'hCAFE0001);
    repeat (3) cycle();

    // Random traffic against the model
    rand_mode = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      CLR = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
